// File: rtl/reg_bus_reader_if.sv
// Bus/handshake bundle between the control unit (master) and reg_bus_reader (slave).
interface reg_bus_reader_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
);
    logic [WIDTH*NREGS-1:0] RegBank;
    logic [WIDTH-1:0]       DIN;
    logic                   Req;
    logic [3:0]             Sel;
    logic [2:0]             Count;
    logic [WIDTH-1:0]       BusOut;
    logic                   BusValid;
    logic                   Busy;
    logic                   Ack;
    logic                   Err;

    modport master (
        output RegBank, DIN, Req, Sel, Count,
        input  BusOut, BusValid, Busy, Ack, Err
    );

    modport slave (
        input  RegBank, DIN, Req, Sel, Count,
        output BusOut, BusValid, Busy, Ack, Err
    );
endinterface

// File: rtl/reg_bus_reader.sv
// Register-bank read port: drives R0..R7 or DIN onto the bus under a four-phase req/ack.
// Define REG_BUS_READER_BURST_EN to honour Count and stream consecutive registers.
module reg_bus_reader #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input logic             Clock,
    input logic             Resetn,
    reg_bus_reader_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t state;

    function automatic logic [WIDTH-1:0] pick(input logic [3:0]             s,
                                              input logic [WIDTH*NREGS-1:0] bank,
                                              input logic [WIDTH-1:0]       din);
        if (s == 4'd8) return din;
        if (s > 4'd8) return '0;
        return bank[WIDTH*int'(s[2:0]) +: WIDTH];
    endfunction

`ifdef REG_BUS_READER_BURST_EN
    logic [3:0] src;
    logic [2:0] remaining;

    // DIN stays on source 8 and is resampled; registers wrap 7 -> 0.
    function automatic logic [3:0] next_src(input logic [3:0] s);
        if (s == 4'd8) return 4'd8;
        return {1'b0, s[2:0] + 3'd1};
    endfunction
`else
    logic count_unused;
    assign count_unused = ^bus.Count;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state        <= IDLE;
            bus.BusOut   <= '0;
            bus.BusValid <= 1'b0;
            bus.Busy     <= 1'b0;
            bus.Ack      <= 1'b0;
            bus.Err      <= 1'b0;
`ifdef REG_BUS_READER_BURST_EN
            src          <= '0;
            remaining    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Req) begin
                        bus.Busy <= 1'b1;
                        if (bus.Sel <= 4'd8) begin
                            bus.BusOut   <= pick(bus.Sel, bus.RegBank, bus.DIN);
                            bus.BusValid <= 1'b1;
                            bus.Err      <= 1'b0;
                            state        <= DRIVE;
`ifdef REG_BUS_READER_BURST_EN
                            src          <= bus.Sel;
                            remaining    <= bus.Count;
`endif
                        end else begin
                            // Invalid source: no data phase, acknowledge with an error.
                            bus.BusOut <= '0;
                            bus.Err    <= 1'b1;
                            bus.Ack    <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DRIVE: begin
`ifdef REG_BUS_READER_BURST_EN
                    if (remaining != 3'd0) begin
                        src        <= next_src(src);
                        bus.BusOut <= pick(next_src(src), bus.RegBank, bus.DIN);
                        remaining  <= remaining - 3'd1;
                    end else
`endif
                    begin
                        bus.BusValid <= 1'b0;
                        bus.Ack      <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.Req) begin
                        bus.Ack  <= 1'b0;
                        bus.Busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_reader.sv
// Directed bench for reg_bus_reader: single-read vector table plus burst, reset and handshake sequences.
module tb_reg_bus_reader;

    logic clk;
    logic rstn;
    int   tests;
    int   fails;

    reg_bus_reader_if #(.WIDTH(16), .NREGS(8)) bus ();

    reg_bus_reader #(.WIDTH(16), .NREGS(8)) dut (
        .Clock (clk),
        .Resetn(rstn),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] din;
        logic [15:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];
    logic [15:0] regs[8];
    logic [15:0] burst_exp[4];
    int          burst_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk(name, {bus.BusOut, bus.BusValid, bus.Busy, bus.Ack, bus.Err}, 20'h0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        regs[0] = 16'h0100; regs[1] = 16'h0101; regs[2] = 16'h2222; regs[3] = 16'h3333;
        regs[4] = 16'h4444; regs[5] = 16'hA5A5; regs[6] = 16'h0006; regs[7] = 16'h0007;
        for (int i = 0; i < 8; i++) bus.RegBank[16*i +: 16] = regs[i];

        vecs[0] = '{4'd5,  16'h0000, 16'hA5A5, 1'b0};
        vecs[1] = '{4'd8,  16'h1234, 16'h1234, 1'b0};
        vecs[2] = '{4'd12, 16'h5555, 16'h0000, 1'b1};
        vecs[3] = '{4'd3,  16'h0000, 16'h3333, 1'b0};
        vecs[4] = '{4'd15, 16'h0000, 16'h0000, 1'b1};
        vecs[5] = '{4'd8,  16'hFFFF, 16'hFFFF, 1'b0};
        vecs[6] = '{4'd0,  16'h0000, 16'h0100, 1'b0};
        vecs[7] = '{4'd9,  16'h0000, 16'h0000, 1'b1};

        bus.Req = 1'b0; bus.Sel = 4'd0; bus.Count = 3'd0; bus.DIN = 16'h0;
        rstn = 1'b0;
        #12;
        chk_idle("reset_hold");
        @(negedge clk);
        rstn = 1'b1;
        tick();
        tick();
        chk_idle("idle_after_release");

        // Single-read table
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            bus.Sel = vecs[v].sel; bus.DIN = vecs[v].din; bus.Count = 3'd0; bus.Req = 1'b1;
            tick();
            chk($sformatf("v%0d_accept_out", v), {16'h0, bus.BusOut}, {16'h0, vecs[v].exp_out});
            chk($sformatf("v%0d_accept_ctl", v), {bus.BusValid, bus.Busy, bus.Ack, bus.Err},
                {~vecs[v].exp_err, 1'b1, vecs[v].exp_err, vecs[v].exp_err});
            if (!vecs[v].exp_err) begin
                @(negedge clk);
                bus.Sel = 4'd1; bus.DIN = 16'h0;
                tick();
                chk($sformatf("v%0d_done", v), {bus.BusOut, bus.BusValid, bus.Ack},
                    {vecs[v].exp_out, 1'b0, 1'b1});
            end
            @(negedge clk);
            bus.Req = 1'b0;
            tick();
            chk($sformatf("v%0d_idle", v), {bus.Busy, bus.Ack, bus.Err}, {1'b0, 1'b0, vecs[v].exp_err});
        end

        // Burst with wrap-around 6,7,0,1
`ifdef REG_BUS_READER_BURST_EN
        burst_exp[0] = 16'h0006; burst_exp[1] = 16'h0007; burst_exp[2] = 16'h0100; burst_exp[3] = 16'h0101;
        burst_n = 4;
`else
        burst_exp[0] = 16'h0006; burst_exp[1] = 16'h0; burst_exp[2] = 16'h0; burst_exp[3] = 16'h0;
        burst_n = 1;
`endif
        @(negedge clk);
        bus.Sel = 4'd6; bus.Count = 3'd3; bus.Req = 1'b1;
        for (int i = 0; i < burst_n; i++) begin
            tick();
            chk($sformatf("burst_w%0d", i), {bus.BusOut, bus.BusValid, bus.Ack}, {burst_exp[i], 1'b1, 1'b0});
        end
        tick();
        chk("burst_end", {bus.BusOut, bus.BusValid, bus.Ack}, {burst_exp[burst_n-1], 1'b0, 1'b1});
        @(negedge clk);
        bus.Req = 1'b0;
        tick();
        chk("burst_idle", {bus.Busy, bus.Ack}, 2'b00);

        // Reset in the middle of a long burst
        @(negedge clk);
        bus.Sel = 4'd0; bus.Count = 3'd7; bus.Req = 1'b1;
        tick();
        chk("mid_w0", {16'h0, bus.BusOut}, {16'h0, regs[0]});
        tick();
        tick();
`ifdef REG_BUS_READER_BURST_EN
        chk("mid_w2", {bus.BusOut, bus.BusValid, bus.Ack}, {regs[2], 1'b1, 1'b0});
`else
        chk("mid_done", {bus.BusOut, bus.BusValid, bus.Ack}, {regs[0], 1'b0, 1'b1});
`endif
        #2;
        rstn = 1'b0;
        #1;
        chk_idle("mid_async_reset");
        bus.Sel = 4'd2; bus.Count = 3'd0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("post_reset_read", {bus.BusOut, bus.BusValid, bus.Busy}, {regs[2], 1'b1, 1'b1});
        tick();
        @(negedge clk);
        bus.Req = 1'b0;
        tick();
        chk("post_reset_idle", {bus.Busy, bus.Ack}, 2'b00);

        // Req held long after Ack
        @(negedge clk);
        bus.Sel = 4'd4; bus.Req = 1'b1;
        tick();
        chk("hold_accept", {16'h0, bus.BusOut}, {16'h0, regs[4]});
        tick();
        chk("hold_ack", {bus.Ack, bus.BusValid}, 2'b10);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold_c%0d", i), {bus.BusOut, bus.BusValid, bus.Busy, bus.Ack},
                {regs[4], 1'b0, 1'b1, 1'b1});
        end
        @(negedge clk);
        bus.Req = 1'b0;
        tick();
        chk("hold_release", {bus.Busy, bus.Ack}, 2'b00);
        @(negedge clk);
        bus.Sel = 4'd7; bus.Req = 1'b1;
        tick();
        chk("hold_new_req", {bus.BusOut, bus.BusValid}, {regs[7], 1'b1});
        @(negedge clk);
        bus.Req = 1'b0;
        tick();
        chk("hold_new_done", {bus.Ack, bus.BusValid}, 2'b10);
        tick();
        chk("hold_new_idle", {bus.Busy, bus.Ack}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_bus_reader.md
# reg_bus_reader

Read side of the processor's 16-bit general-register bank. It selects one of the R0–R7 register outputs, or the external DIN word, and drives the value onto the processor bus through a registered output, under a four-phase req/ack handshake with the control unit. The R-registers load from the bus; this block is what puts their contents back onto it. An optional burst mode streams consecutive registers on consecutive cycles.

## Interface
- `WIDTH`, 16: bus/register word width.
- `NREGS`, 8: number of general registers (R0..R(NREGS-1)); fixed at 8 for this design.

- `Clock` in 1: single clock; all state changes on rising edge.
- `Resetn` in 1: asynchronous, active-low reset.
- `RegBank` in WIDTH*NREGS: flattened register outputs; R*i* occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i].
- `DIN` in WIDTH: external data word.
- `Req` in 1: read request (level, four-phase).
- `Sel` in 4: source code; 0–7 selects R0–R7, 8 selects DIN, 9–15 are invalid.
- `Count` in 3: extra words in a burst (burst length = Count+1); used only with the burst feature.
- `BusOut` out WIDTH: registered bus value.
- `BusValid` out 1: BusOut holds a word being read this cycle.
- `Busy` out 1: a transfer is in progress (state ≠ IDLE).
- `Ack` out 1: transfer complete; four-phase acknowledge.
- `Err` out 1: last accepted request had an invalid Sel.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE: Busy=0, BusValid=0, Ack=0. On an edge with Req=1, the block latches Sel and Count.
  - If Sel ≤ 8: it loads BusOut with the selected source, sets BusValid=1, clears Err, and moves to DRIVE. The remaining-word counter is loaded with Count when burst is enabled, otherwise 0.
  - If Sel ≥ 9: it sets BusOut=0 and Err=1, keeps BusValid=0, and moves directly to DONE.
- DRIVE, with remaining > 0: each edge advances the source and reloads BusOut, and decrements remaining.
  - Register sources advance 7→0 with wrap-around.
  - Source 8 (DIN) does not advance; DIN is resampled each cycle.
- DRIVE, with remaining = 0: the next edge moves to DONE, sets BusValid=0 and Ack=1, and holds BusOut at the last word.
- DONE: Ack stays 1 while Req=1. The first edge with Req=0 moves to IDLE and sets Ack=0. A new request is never accepted in the same edge as the DONE→IDLE transition.
- Req changes during DRIVE are ignored. Sel, Count and DIN changes after acceptance affect only which DIN value is sampled.
- Source values are sampled as present just before the loading edge. A register written at that same edge is read with its old value.
- Err persists until the next accepted request.

## Timing
- Reset (Resetn=0, asynchronous, any state including mid-burst): state IDLE, BusOut=0, BusValid=0, Busy=0, Ack=0, Err=0, internal counters 0. Outputs clear without waiting for a clock edge. Release is synchronous to the next edge.
- Latency: BusOut valid 1 cycle after the edge that samples Req=1 in IDLE.
- A burst of N words gives BusValid high for exactly N consecutive cycles. Ack rises on the edge after the last word.
- Minimum transaction: accept edge, DONE edge, IDLE edge. Back-to-back single reads therefore take ≥3 cycles each.
- Busy rises on the accept edge and falls on the DONE→IDLE edge.

## Configuration
- `REG_BUS_READER_BURST_EN` defined: Count is honoured and bursts of 1–8 words are supported with wrap-around as above.
- Not defined: Count is ignored, every transfer is a single word, and the remaining-word counter is not synthesised.

## Test plan
- Reset then idle: assert Resetn=0 mid-cycle -> all outputs 0 immediately. Release with Req=0 -> outputs remain 0.
- Single read: R5=16'hA5A5, Sel=5, Req=1 -> next cycle BusOut=A5A5 and BusValid=1 for 1 cycle. Ack=1 on the following edge and held until Req=0, then IDLE.
- DIN read and invalid select: Sel=8, DIN=16'h1234 -> BusOut=1234. Then Sel=12 -> BusValid never rises, BusOut=0, Err=1, Ack=1. A following valid read clears Err.
- Burst with wrap (macro on): R6=6, R7=7, R0=0x100, R1=0x101, Sel=6, Count=3 -> BusOut sequence 6, 7, 0x100, 0x101 on 4 consecutive cycles, then Ack. With the macro off, the same stimulus -> single word 6.
- Reset mid-burst: Sel=0, Count=7, assert Resetn=0 after word 3 -> outputs 0 asynchronously. After release, a Req gives a fresh single/burst from the new Sel.
- Handshake hold: keep Req=1 for 10 cycles after Ack -> Ack stays 1 and no second transfer occurs. Drop Req for one edge -> IDLE, then a new Req is accepted.
